// File: rtl/mips_pkg.sv
// Shared encodings for the multiply/divide path and the hazard unit.
package mips_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIN  = 2'b10
    } state_e;

    // Bit 1 of the opcode selects divide, bit 0 selects signed.
    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterate-only datapath: one shift-add (multiply) or one restoring
// subtract (divide) step per cycle on unsigned magnitudes, plus the
// iteration counter. Sign handling lives in the wrapper.
module muldiv_core
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] upper,
    output logic [WIDTH-1:0] lower,
    output logic             last
);

    localparam int CNT_W = $clog2(WIDTH);

    // acc_hi holds the running product upper half or the partial remainder;
    // acc_lo holds the multiplier being shifted out or the quotient shifted in.
    logic [WIDTH:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             div_ge;

    // One iteration of shift-add or restoring division, or an operand load.
    always_comb begin
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opb_d     = opb_q;
        cnt_d     = cnt_q;

        mul_sum   = acc_hi_q + (acc_lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
        div_ge    = ~div_diff[WIDTH+1];

        if (load) begin
            acc_hi_d = '0;
            acc_lo_d = opa;
            opb_d    = opb;
            cnt_d    = '0;
        end else if (step) begin
            if (is_div) begin
                acc_hi_d = div_ge ? div_diff[WIDTH:0] : div_shift;
                acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
            end else begin
                acc_hi_d = {1'b0, mul_sum[WIDTH:1]};
                acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Datapath and counter registers; cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
        end else begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
        end
    end

    assign upper = acc_hi_q[WIDTH-1:0];
    assign lower = acc_lo_q;
    assign last  = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: FSM, operand sign handling, flush/reset
// policy and the architectural HI/LO registers around muldiv_core.
module ex_muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_r1,
    input  logic [WIDTH-1:0] data_r2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    // Magnitude of an operand: two's-complement absolute value when signed.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
    endfunction

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic             negp_q, negp_d;
    logic             negr_q, negr_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             dbzo_q, dbzo_d;

    op_e              op_in;
    logic             accept;
    logic             commit;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] core_a, core_b;
    logic [WIDTH-1:0] core_upper, core_lower;
    logic             core_last;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    assign op_in  = op_e'(op);
    assign accept = (state_q == S_IDLE) && start && !flush;
    assign mag_a  = mag(data_r1, op_is_signed(op_in));
    assign mag_b  = mag(data_r2, op_is_signed(op_in));
    // Divide iterates dividend through the low register; multiply shifts
    // the multiplier (rt) out of it and adds the multiplicand (rs).
    assign core_a = op_is_div(op_in) ? mag_a : mag_b;
    assign core_b = op_is_div(op_in) ? mag_b : mag_a;

    muldiv_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (accept),
        .step   (state_q == S_RUN),
        .is_div (op_is_div(op_q)),
        .opa    (core_a),
        .opb    (core_b),
        .upper  (core_upper),
        .lower  (core_lower),
        .last   (core_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush always returns to IDLE and blocks a start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_RUN;
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (core_last) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/commit decode: commit only from FIN without a flush.
    always_comb begin
        commit = (state_q == S_FIN) && !flush;
        busy_d = (state_d != S_IDLE);
        done_d = commit;
    end

    // Operand capture on accept and sign-corrected result on commit.
    always_comb begin
        op_d   = op_q;
        negp_d = negp_q;
        negr_d = negr_q;
        dbz_d  = dbz_q;
        dvd_d  = dvd_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        dbzo_d = dbzo_q;

        prod = negp_q ? -{core_upper, core_lower} : {core_upper, core_lower};
        quo  = negp_q ? -core_lower : core_lower;
        rem  = negr_q ? -core_upper : core_upper;

        if (accept) begin
            op_d   = op_in;
            negp_d = op_is_signed(op_in) && (data_r1[WIDTH-1] ^ data_r2[WIDTH-1]);
            negr_d = op_is_signed(op_in) && op_is_div(op_in) && data_r1[WIDTH-1];
            dbz_d  = op_is_div(op_in) && (data_r2 == '0);
            dvd_d  = data_r1;
        end

        if (commit) begin
            if (!op_is_div(op_q)) begin
                hi_d   = prod[2*WIDTH-1:WIDTH];
                lo_d   = prod[WIDTH-1:0];
                dbzo_d = 1'b0;
            end else if (dbz_q) begin
                hi_d   = dvd_q;
                lo_d   = '1;
                dbzo_d = 1'b1;
            end else begin
                hi_d   = rem;
                lo_d   = quo;
                dbzo_d = 1'b0;
            end
        end
    end

    // Control, operand-side and architectural registers; all cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q   <= OP_MULTU;
            negp_q <= 1'b0;
            negr_q <= 1'b0;
            dbz_q  <= 1'b0;
            dvd_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            dbzo_q <= 1'b0;
        end else begin
            op_q   <= op_d;
            negp_q <= negp_d;
            negr_q <= negr_d;
            dbz_q  <= dbz_d;
            dvd_q  <= dvd_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
            busy_q <= busy_d;
            dbzo_q <= dbzo_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbzo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit.
module tb_ex_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data_r1;
    logic [31:0] data_r2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .data_r1     (data_r1),
        .data_r2     (data_r2),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: 64-bit arithmetic in the bench.
    task automatic push_exp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb2, q, r;
        logic [63:0] p;
        e.dbz = 1'b0;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        case (o)
            2'b00: begin
                p = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b01: begin
                p = sa * sb2;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi  = a;
                    e.lo  = 32'hFFFF_FFFF;
                    e.dbz = 1'b1;
                end else if (o == 2'b10) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end else begin
                    q = sa / sb2;
                    r = sa % sb2;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end
            end
        endcase
        sb.push_back(e);
    endtask

    // Issue one op at the current negedge and follow it to completion.
    // If hold is set, start stays high with junk operands while busy.
    task automatic run_op(input string name, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b, input bit hold);
        exp_t e;
        int   k;
        int   busy_n;
        bit   got;
        start   = 1'b1;
        op      = o;
        data_r1 = a;
        data_r2 = b;
        push_exp(o, a, b);
        @(negedge clk);
        if (hold) begin
            start   = 1'b1;
            op      = ~o;
            data_r1 = 32'h1234_5678;
            data_r2 = 32'h0000_0003;
        end else begin
            start = 1'b0;
        end
        k = 0;
        busy_n = 0;
        got = 0;
        while (k <= 40) begin
            if (done === 1'b1) begin
                got = 1;
                break;
            end
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
            k++;
            if (hold && k == 31) start = 1'b0;
        end
        e = sb.pop_front();
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s timeout: done not seen within %0d cycles, required after 33", name, k);
            return;
        end
        if (k !== 33) begin
            bad++;
            $display("FAIL %s latency: done after %0d edges, required 33", name, k);
        end
        total++;
        if (busy_n !== 33) begin
            bad++;
            $display("FAIL %s busy_cycles: got %0d required 33", name, busy_n);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_in_done_cycle: got %b required 0", name, busy);
        end
        total++;
        if (hi !== e.hi) begin
            bad++;
            $display("FAIL %s hi: got %h required %h", name, hi, e.hi);
        end
        total++;
        if (lo !== e.lo) begin
            bad++;
            $display("FAIL %s lo: got %h required %h", name, lo, e.lo);
        end
        total++;
        if (div_by_zero !== e.dbz) begin
            bad++;
            $display("FAIL %s div_by_zero: got %b required %b", name, div_by_zero, e.dbz);
        end
    endtask

    task automatic check_all_zero(input string name);
        total++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            bad++;
            $display("FAIL %s hi_lo: got %h/%h required 0/0", name, hi, lo);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
            bad++;
            $display("FAIL %s flags busy/done/dbz: got %b%b%b required 000", name, busy, done, div_by_zero);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; data_r1 = '0; data_r2 = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("mult_min_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("mult_m3_7", 2'b01, 32'hFFFF_FFFD, 32'd7, 0);
    endtask

    task automatic test_div();
        run_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 0);
        run_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("div_7_m2", 2'b11, 32'd7, 32'hFFFF_FFFE, 0);
    endtask

    task automatic test_div_by_zero();
        run_op("divu_5_0", 2'b10, 32'd5, 32'd0, 0);
        run_op("div_m9_0", 2'b11, 32'hFFFF_FFF7, 32'd0, 0);
        // Back-to-back issue in the done cycle; also clears the flag.
        run_op("multu_3_4", 2'b00, 32'd3, 32'd4, 0);
    endtask

    task automatic test_flush();
        start = 1'b1; op = 2'b01; data_r1 = 32'd2; data_r2 = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        start = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle busy: got %b required 0", busy);
        end
        total++;
        if (hi !== 32'd0 || lo !== 32'd12) begin
            bad++;
            $display("FAIL flush_retain hi/lo: got %h/%h required 0/c", hi, lo);
        end
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL flush_done: got %b required 0", done);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_start_ignored busy: got %b required 0", busy);
        end
        flush = 1'b0;
        start = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) break;
        end
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || lo !== 32'd12) begin
            bad++;
            $display("FAIL flush_aftermath done/busy/lo: got %b/%b/%h required 0/0/c", done, busy, lo);
        end
    endtask

    task automatic test_start_while_busy();
        run_op("divu_hold_start", 2'b10, 32'd100, 32'd7, 1);
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1; op = 2'b00; data_r1 = 32'd9; data_r2 = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check_all_zero("reset_mid_run");
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_recover busy: got %b required 0", busy);
        end
        run_op("after_reset_mult", 2'b01, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_mul();
        test_div();
        test_div_by_zero();
        test_flush();
        test_start_while_busy();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
